wheel_step_counter: RTL and testbench

- Sits directly downstream of the quadrature wheel decoder FSM.
- Consumes its one-cycle step strobe (registra) qualified by direction flags (dir_cw / dir_ccw), and keeps a signed wheel position.
- Every fixed measurement window, publishes a signed step count (speed) and a stopped flag, for the vehicle control logic.
- Detects malformed strobes.

---
 rtl/wheel_step_counter_if.sv | 30 +++
 rtl/wheel_step_counter.sv | 121 ++++++++++++
 tb/tb_wheel_step_counter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wheel_step_counter_if.sv
// Step-strobe input and position/speed report bundle
// between the wheel decoder and the vehicle control logic.
interface wheel_step_counter_if #(
    parameter int POS_W = 16,
    parameter int SPD_W = 8
);
    logic                    registra;
    logic                    dir_cw;
    logic                    dir_ccw;
    logic                    clear;
    logic signed [POS_W-1:0] position;
    logic signed [SPD_W-1:0] speed;
    logic                    speed_valid;
    logic                    dir_last;
    logic                    stopped;
    logic                    pos_sat;
    logic                    err;

    modport master (
        output registra, dir_cw, dir_ccw, clear,
        input  position, speed, speed_valid,
        input  dir_last, stopped, pos_sat, err
    );

    modport slave (
        input  registra, dir_cw, dir_ccw, clear,
        output position, speed, speed_valid,
        output dir_last, stopped, pos_sat, err
    );
endinterface

// File: rtl/wheel_step_counter.sv
// Saturating wheel position tracker with per-window
// signed speed report, stopped flag and malformed-strobe flag.
module wheel_step_counter #(
    parameter int POS_W         = 16,
    parameter int SPD_W         = 8,
    parameter int WINDOW_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    wheel_step_counter_if.slave   bus
);
    localparam int CNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic signed [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};
    localparam logic signed [SPD_W-1:0] SPD_ONE = SPD_W'(1);

    logic [CNT_W-1:0]        r_win;
    logic signed [POS_W-1:0] r_position;
    logic signed [SPD_W-1:0] r_acc;
    logic signed [SPD_W-1:0] r_speed;
    logic                    r_speed_valid;
    logic                    r_dir_last;
    logic                    r_stopped;
    logic                    r_pos_sat;
    logic                    r_err;

    logic                    w_cw;
    logic                    w_ccw;
    logic                    w_bad;
    logic                    w_term;
    logic signed [SPD_W-1:0] w_acc_nx;

    // Classify the strobe; direction flags only matter while it is high.
    always_comb begin
        w_cw   = bus.registra & bus.dir_cw & ~bus.dir_ccw;
        w_ccw  = bus.registra & ~bus.dir_cw & bus.dir_ccw;
        w_bad  = bus.registra & (bus.dir_cw ~^ bus.dir_ccw);
        w_term = (r_win == CNT_LAST);
    end

    // Window accumulator including this cycle's step, clamped at the rails.
    always_comb begin
        w_acc_nx = r_acc;
        if (w_cw && (r_acc != SPD_MAX)) begin
            w_acc_nx = r_acc + SPD_ONE;
        end else if (w_ccw && (r_acc != SPD_MIN)) begin
            w_acc_nx = r_acc - SPD_ONE;
        end
    end

    // All state: reset, then soft clear, then normal step/window update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_win         <= '0;
            r_position    <= '0;
            r_acc         <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_dir_last    <= 1'b0;
            r_stopped     <= 1'b1;
            r_pos_sat     <= 1'b0;
            r_err         <= 1'b0;
        end else if (bus.clear) begin
            r_win         <= '0;
            r_position    <= '0;
            r_acc         <= '0;
            r_speed_valid <= 1'b0;
            r_dir_last    <= 1'b0;
            r_pos_sat     <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_win <= w_term ? '0 : r_win + CNT_ONE;

            if (w_cw) begin
                r_dir_last <= 1'b1;
                if (r_position == POS_MAX) begin
                    r_pos_sat <= 1'b1;
                end else begin
                    r_position <= r_position + POS_ONE;
                end
            end else if (w_ccw) begin
                r_dir_last <= 1'b0;
                if (r_position == POS_MIN) begin
                    r_pos_sat <= 1'b1;
                end else begin
                    r_position <= r_position - POS_ONE;
                end
            end

            if (w_bad) begin
                r_err <= 1'b1;
            end

            if (w_term) begin
                r_speed       <= w_acc_nx;
                r_speed_valid <= 1'b1;
                r_stopped     <= (w_acc_nx == '0);
                r_acc         <= '0;
            end else begin
                r_speed_valid <= 1'b0;
                r_acc         <= w_acc_nx;
            end
        end
    end

    assign bus.position    = r_position;
    assign bus.speed       = r_speed;
    assign bus.speed_valid = r_speed_valid;
    assign bus.dir_last    = r_dir_last;
    assign bus.stopped     = r_stopped;
    assign bus.pos_sat     = r_pos_sat;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_wheel_step_counter.sv
// Directed plus random stimulus for wheel_step_counter,
// checked every cycle against an integer reference model.
module tb_wheel_step_counter;
    localparam int POS_W = 8;
    localparam int SPD_W = 4;
    localparam int WIN   = 16;
    localparam int PMAX  = 127;
    localparam int PMIN  = -128;
    localparam int SMAX  = 7;
    localparam int SMIN  = -8;

    logic clk = 1'b0;
    logic reset;

    wheel_step_counter_if #(.POS_W(POS_W), .SPD_W(SPD_W)) bus ();

    wheel_step_counter #(
        .POS_W(POS_W),
        .SPD_W(SPD_W),
        .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference state: plain integers, time since window start as a count.
    int m_pos, m_acc, m_cycles, m_speed;
    int m_sv, m_dir, m_stop, m_psat, m_err;

    task automatic chk(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model(input bit rn, input bit clr, input bit r,
                         input bit cw, input bit ccw);
        int d;
        int a;
        if (!rn) begin
            m_pos = 0; m_acc = 0; m_cycles = 0; m_speed = 0;
            m_sv = 0; m_dir = 0; m_stop = 1; m_psat = 0; m_err = 0;
        end else if (clr) begin
            m_pos = 0; m_acc = 0; m_cycles = 0; m_sv = 0;
            m_dir = 0; m_psat = 0; m_err = 0;
        end else begin
            d = 0;
            if (r && cw && !ccw) d = 1;
            if (r && !cw && ccw) d = -1;
            if (r && (cw == ccw)) m_err = 1;
            if (d != 0) begin
                m_dir = (d > 0);
                if (m_pos + d > PMAX || m_pos + d < PMIN) m_psat = 1;
                else m_pos = m_pos + d;
            end
            a = clamp(m_acc + d, SMIN, SMAX);
            if ((m_cycles % WIN) == WIN - 1) begin
                m_speed = a;
                m_sv    = 1;
                m_stop  = (a == 0);
                m_acc   = 0;
            end else begin
                m_sv  = 0;
                m_acc = a;
            end
            m_cycles++;
        end
    endtask

    task automatic tick(input bit r, input bit cw, input bit ccw,
                        input bit clr, input bit rn);
        bus.registra = r;
        bus.dir_cw   = cw;
        bus.dir_ccw  = ccw;
        bus.clear    = clr;
        reset        = rn;
        @(posedge clk);
        model(rn, clr, r, cw, ccw);
        #1;
        chk("position",    bus.position,    m_pos);
        chk("speed",       bus.speed,       m_speed);
        chk("speed_valid", bus.speed_valid, m_sv);
        chk("dir_last",    bus.dir_last,    m_dir);
        chk("stopped",     bus.stopped,     m_stop);
        chk("pos_sat",     bus.pos_sat,     m_psat);
        chk("err",         bus.err,         m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.registra = 0; bus.dir_cw = 0; bus.dir_ccw = 0;
        bus.clear = 0; reset = 0;
        #1;

        // Reset state, then a quiet 40 cycles.
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("rst_stopped", bus.stopped, 1);
        idle(40);

        // 5 CW then 2 CCW right after reset release.
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) tick(1, 0, 1, 0, 1);
        chk("pos_after_5cw_2ccw", bus.position, 3);
        chk("dir_after_ccw", bus.dir_last, 0);
        idle(12);

        // Malformed strobes, sticky err, cleared by clear.
        tick(1, 1, 1, 0, 1);
        tick(1, 0, 0, 0, 1);
        chk("err_sticky", bus.err, 1);
        idle(5);
        tick(0, 0, 0, 1, 1);
        chk("err_cleared", bus.err, 0);

        // 130 CW steps: position and accumulator both saturate.
        for (int i = 0; i < 130; i++) tick(1, 1, 0, 0, 1);
        chk("pos_sat_val", bus.position, PMAX);
        chk("pos_sat_flag", bus.pos_sat, 1);
        idle(20);

        // CCW saturation at the negative rail.
        tick(0, 0, 0, 1, 1);
        for (int i = 0; i < 131; i++) tick(1, 0, 1, 0, 1);
        chk("neg_sat_val", bus.position, PMIN);

        // CW step on the terminal cycle, then CW coincident with clear.
        tick(0, 0, 0, 1, 1);
        while ((m_cycles % WIN) != WIN - 1) tick(0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 1);
        chk("term_step_speed", bus.speed, 1);
        tick(1, 1, 0, 1, 1);
        chk("clear_drops_step", bus.position, 0);

        // Net-zero window reports stopped.
        idle(3);
        tick(1, 1, 0, 0, 1);
        tick(1, 0, 1, 0, 1);
        idle(WIN);

        // Reset for one cycle at counter 9 with position 20.
        for (int i = 0; i < 20; i++) tick(1, 1, 0, 0, 1);
        while ((m_cycles % WIN) != 9) tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        chk("mid_reset_pos", bus.position, 0);
        idle(40);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 149) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
